// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, grant encoding and
// the wait-counter ceiling.
package arb_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  localparam logic [15:0] WAIT_CNT_MAX = 16'hFFFF;

  function automatic arb_state_t busy_state(input arb_grant_t g);
    arb_state_t s;
    if (g == GRANT_I) begin
      s = I_BUSY;
    end else begin
      s = D_BUSY;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_arbiter_priority.sv
// Combinational grant selection for the memory arbiter.
// MEM_ARBITER_RR_EN selects round-robin; otherwise the data side wins contention.
module arb_priority
  import arb_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output logic       grant_valid,
  output arb_grant_t grant
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARBITER_RR_EN
  // Contention goes to whichever side was not granted last.
  always_comb begin
    grant = GRANT_D;
    if (i_req && d_req) begin
      if (last_grant == GRANT_D) begin
        grant = GRANT_I;
      end else begin
        grant = GRANT_D;
      end
    end else if (i_req) begin
      grant = GRANT_I;
    end else begin
      grant = GRANT_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == GRANT_D);

  // Fixed priority: the data side always wins contention.
  always_comb begin
    grant = GRANT_D;
    if (d_req) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end else begin
      grant = GRANT_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory port.
// Define MEM_ARBITER_RR_EN for round-robin contention handling.
module mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_read,
  input  logic [ADDR_WIDTH-1:0]     i_address,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  output logic                      i_resp,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [ADDR_WIDTH-1:0]     d_address,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_enable,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [ADDR_WIDTH-1:0]     pmem_address,
  output logic [DATA_WIDTH-1:0]     pmem_wdata,
  output logic [DATA_WIDTH/8-1:0]   pmem_byte_enable,
  input  logic [DATA_WIDTH-1:0]     pmem_rdata,
  input  logic                      pmem_resp
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  arb_grant_t last_grant_r;
  arb_grant_t grant_s;
  logic       grant_valid_s;
  logic       d_req_s;
  logic       take_s;
  logic       done_s;
  logic [15:0] d_wait_cnt;

  assign d_req_s = d_read | d_write;
  assign take_s  = (state_r == IDLE) && grant_valid_s;
  assign done_s  = (state_r != IDLE) && pmem_resp;

  arb_priority u_priority (
    .i_req       (i_read),
    .d_req       (d_req_s),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // Next-state logic; stray pmem_resp in IDLE falls through untouched.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_nxt_s = busy_state(grant_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and round-robin pointer (reset to data-last-granted).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_D;
    end else begin
      state_r <= state_nxt_s;
      if (take_s) begin
        last_grant_r <= grant_s;
      end
    end
  end

  // Shared-port request fields, captured once at grant and held until resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else if (take_s) begin
      if (grant_s == GRANT_I) begin
        pmem_read        <= 1'b1;
        pmem_write       <= 1'b0;
        pmem_address     <= i_address;
        pmem_wdata       <= '0;
        pmem_byte_enable <= '0;
      end else begin
        pmem_read        <= ~d_write;
        pmem_write       <= d_write;
        pmem_address     <= d_address;
        pmem_wdata       <= d_wdata;
        pmem_byte_enable <= d_byte_enable;
      end
    end else if (done_s) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  // Completion routing: only the granted side sees resp and read data.
  always_comb begin
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    if (pmem_resp && (state_r == I_BUSY)) begin
      i_resp  = 1'b1;
      i_rdata = pmem_rdata;
    end else if (pmem_resp && (state_r == D_BUSY)) begin
      d_resp  = 1'b1;
      d_rdata = pmem_rdata;
    end else begin
      i_resp = 1'b0;
      d_resp = 1'b0;
    end
  end

  // Debug counter of data-side cycles spent waiting outside D_BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_wait_cnt <= 16'd0;
    end else if (d_resp) begin
      d_wait_cnt <= 16'd0;
    end else if (d_req_s && (state_r != D_BUSY) && (d_wait_cnt != WAIT_CNT_MAX)) begin
      d_wait_cnt <= d_wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow
// MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_address = 32'd0;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_address = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_byte_enable = 4'd0;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata = 32'd0;
  logic        pmem_resp = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic test_reset();
    #3;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    checks++;
    if ({pmem_address, pmem_wdata, pmem_byte_enable} !== 68'd0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {pmem_address, pmem_wdata, pmem_byte_enable});
    end
    checks++;
    if (dut.d_wait_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.d_wait_cnt);
    end
    pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_i_read();
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h60;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++; $display("FAIL iread_c0_pmem_read: got %b want 0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 32'h60}) begin
      errors++; $display("FAIL iread_c1_req: got %b%b %h want 10 00000060", pmem_read, pmem_write, pmem_address);
    end
    checks++;
    if ({i_resp, i_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL iread_c1_resp: got %b %h want 1 deadbeef", i_resp, i_rdata);
    end
    checks++;
    if ({d_resp, d_rdata} !== 33'd0) begin
      errors++; $display("FAIL iread_c1_dside: got %b %h want 0 0", d_resp, d_rdata);
    end
    @(negedge clk);
    i_read = 1'b0; pmem_resp = 1'b0;
    #1;
    checks++;
    if ({pmem_read, i_resp} !== 2'b00) begin
      errors++; $display("FAIL iread_c2_done: got %b want 00", {pmem_read, i_resp});
    end
  endtask

  task automatic test_d_write();
    @(negedge clk);
    d_write = 1'b1; d_address = 32'h104; d_wdata = 32'h12345678; d_byte_enable = 4'b0011;
    pmem_rdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if (pmem_write !== 1'b0) begin
      errors++; $display("FAIL dwr_c0_pmem_write: got %b want 0", pmem_write);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      pmem_resp = (k == 3);
      if (k == 2) begin
        d_address = 32'hFFF0; d_wdata = 32'h0BADF00D; d_byte_enable = 4'b1100;
      end
      #1;
      checks++;
      if ({pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_byte_enable}
          !== {2'b10, 32'h104, 32'h12345678, 4'b0011}) begin
        errors++; $display("FAIL dwr_c%0d_fields: got %b%b %h %h %b", k, pmem_write, pmem_read,
                           pmem_address, pmem_wdata, pmem_byte_enable);
      end
      checks++;
      if ({d_resp, i_resp} !== {(k == 3), 1'b0}) begin
        errors++; $display("FAIL dwr_c%0d_resp: got d=%b i=%b want d=%b i=0", k, d_resp, i_resp, (k == 3));
      end
    end
    checks++;
    if ({d_rdata, i_rdata} !== {32'hA5A5A5A5, 32'd0}) begin
      errors++; $display("FAIL dwr_rdata_route: got %h %h want a5a5a5a5 0", d_rdata, i_rdata);
    end
    @(negedge clk);
    d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    checks++;
    if ({pmem_write, d_resp} !== 2'b00) begin
      errors++; $display("FAIL dwr_done: got %b want 00", {pmem_write, d_resp});
    end
  endtask

  task automatic test_contention();
    logic exp_i;
    #1 rst = 1'b0;
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h200; d_address = 32'h300;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_i = (t % 2 == 0);
`else
      exp_i = 1'b0;
`endif
      @(negedge clk);
      pmem_resp = 1'b1; pmem_rdata = 32'h1000 + t;
      #1;
      checks++;
      if ({i_resp, d_resp} !== {exp_i, ~exp_i}) begin
        errors++; $display("FAIL cont_t%0d_grant: got i=%b d=%b want i=%b d=%b", t, i_resp, d_resp, exp_i, ~exp_i);
      end
      checks++;
      if ({pmem_read, pmem_address} !== {1'b1, (exp_i ? 32'h200 : 32'h300)}) begin
        errors++; $display("FAIL cont_t%0d_addr: got %b %h", t, pmem_read, pmem_address);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      checks++;
      if ({pmem_read, i_resp, d_resp} !== 3'b000) begin
        errors++; $display("FAIL cont_t%0d_bubble: got %b want 000", t, {pmem_read, i_resp, d_resp});
      end
`ifndef MEM_ARBITER_RR_EN
      checks++;
      if (dut.d_wait_cnt !== 16'd0) begin
        errors++; $display("FAIL cont_t%0d_wait_cnt: got %0d want 0", t, dut.d_wait_cnt);
      end
`endif
    end
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_read = 1'b1; d_address = 32'h40;
    @(negedge clk);
    #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got %b want 1", pmem_read);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, pmem_address} !== 34'd0) begin
      errors++; $display("FAIL rstmid_async: got %b%b %h want 0", pmem_read, pmem_write, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({d_resp, i_resp, d_rdata} !== 34'd0) begin
      errors++; $display("FAIL rstmid_resp: got %b%b %h want 0", d_resp, i_resp, d_rdata);
    end
    pmem_resp = 1'b0; d_read = 1'b0;
    @(negedge clk);
    rst = 1'b1; i_read = 1'b1; i_address = 32'h80;
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if ({i_resp, i_rdata, pmem_address} !== {1'b1, 32'hCAFEF00D, 32'h80}) begin
      errors++; $display("FAIL rstmid_after: got %b %h %h want 1 cafef00d 80", i_resp, i_rdata, pmem_address);
    end
    @(negedge clk);
    i_read = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h20; d_wdata = 32'h55AA55AA; d_byte_enable = 4'b1111;
    @(negedge clk);
    d_read = 1'b0;
    #1;
    checks++;
    if ({pmem_write, pmem_read, pmem_wdata} !== {2'b10, 32'h55AA55AA}) begin
      errors++; $display("FAIL rw_write_only: got %b%b %h want 10 55aa55aa", pmem_write, pmem_read, pmem_wdata);
    end
    @(negedge clk);
    d_write = 1'b0; pmem_resp = 1'b1;
    #1;
    checks++;
    if ({d_resp, pmem_write, pmem_read} !== 3'b110) begin
      errors++; $display("FAIL rw_withdrawn_resp: got %b want 110", {d_resp, pmem_write, pmem_read});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({d_resp, i_resp, pmem_write, pmem_read} !== 4'b0000) begin
      errors++; $display("FAIL rw_stray_resp: got %b want 0000", {d_resp, i_resp, pmem_write, pmem_read});
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    checks++;
    if ({pmem_write, pmem_read} !== 2'b00) begin
      errors++; $display("FAIL rw_stays_idle: got %b want 00", {pmem_write, pmem_read});
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_reset_mid();
    test_rw_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
